riscv_seq_ctrl: RTL and testbench
=================================

RISCV_SEQ_CTRL -- requirements
Module: riscv_seq_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port byte_in  input  8  instruction byte from the external byte bus.
REQ-005 SHALL have port byte_valid  input  1  byte_in holds a valid byte.
REQ-006 SHALL have port byte_ready  output  1  block accepts a byte this cycle.
REQ-007 SHALL have port instr  output  32  assembled instruction register, fed to the immediate generator and datapath.
REQ-008 SHALL have port imm  input  32  sign-extended immediate decoded from instr by the immediate generator.
REQ-009 SHALL have port alu_zero  input  1  datapath rs1 - rs2 == 0.
REQ-010 SHALL have port pc  output  32  program counter.
REQ-011 SHALL have port alu_sub  output  1  datapath selects subtract for the compare.
REQ-012 SHALL have port wb_sel  output  1  write-back source: 0 = ALU result (ADDI), 1 = imm (LUI).
REQ-013 SHALL have port rf_we  output  1  register-file write strobe.
REQ-014 SHALL have port state  output  3  current FSM state, for debug.
REQ-015 SHALL have port illegal  output  1  sticky flag for an unsupported opcode.

Function
REQ-016 SHALL implement FSM states FETCH=0, DECODE=1, EXEC=2, WB=3, TRAP=4; state SHALL drive this encoding.
REQ-017 SHALL, in FETCH, drive byte_ready=1; in every other state byte_ready SHALL be 0.
REQ-018 SHALL accept a byte only when byte_valid && byte_ready; on acceptance it SHALL write instr[8*cnt +: 8] = byte_in (little-endian) and increment the 2-bit counter cnt.
REQ-019 SHALL ignore byte_valid while byte_ready=0; no byte is consumed or buffered.
REQ-020 SHALL, on accepting the byte with cnt==3, go FETCH->DECODE next cycle and wrap cnt to 0.
REQ-021 SHALL leave instr and cnt unchanged when byte_valid is low in FETCH; a gap of any length SHALL be tolerated.
REQ-022 SHALL, in DECODE (1 cycle), check opcode instr[6:0]: 0010011 (ADDI), 0110111 (LUI) or 1100011 (BEQ) -> EXEC; any other -> TRAP and set illegal=1.
REQ-023 SHALL, in EXEC for BEQ, assert alu_sub=1; pc <= pc + imm if alu_zero=1, else pc <= pc + 4; then -> FETCH.
REQ-024 SHALL, in EXEC for ADDI/LUI, keep alu_sub=0 and go to WB with pc unchanged.
REQ-025 SHALL, in WB (1 cycle), drive wb_sel=1 for LUI and 0 for ADDI; rf_we=1 unless rd=instr[11:7]==0; pc <= pc + 4; then -> FETCH.
REQ-026 SHALL assert rf_we only in WB, for exactly one cycle per ADDI/LUI.
REQ-027 SHALL decode alu_sub, wb_sel and rf_we from the registered state and instr only (Moore); wb_sel=0 outside WB.
REQ-028 SHALL compute all PC arithmetic modulo 2^32; overflow wraps silently.
REQ-029 SHALL hold TRAP until rst, with pc and instr frozen and illegal=1.
REQ-030 SHALL take 3 cycles from the 4th byte accepted to the next byte_ready for ADDI/LUI (DECODE, EXEC, WB), and 2 cycles for BEQ.

Reset
REQ-031 SHALL, with rst=1 at a clock edge, set state=FETCH, cnt=0, instr=0, pc=RESET_PC, illegal=0; rf_we, alu_sub and wb_sel SHALL be 0.
REQ-032 SHALL let rst take priority over all other events, including a byte accepted in the same cycle; a partial instruction SHALL be discarded.
REQ-033 SHALL, on the first edge after rst deasserts, be in FETCH with byte_ready=1.

Verification
REQ-034 SHALL cover: bytes 93,00,50,00 back-to-back -> instr=0x00500093; rf_we=1 for one cycle 3 cycles after the 4th byte, wb_sel=0; pc 0->4.
REQ-035 SHALL cover: bytes 37,51,34,12 (LUI x2,0x12345) with a 5-cycle byte_valid gap after byte 2 -> instr=0x12345137; in WB wb_sel=1, rf_we=1; pc +4.
REQ-036 SHALL cover: instr 0x00000463 (BEQ +8) at pc=0x10, imm=8 -> alu_zero=1 gives pc=0x18; alu_zero=0 gives pc=0x14; rf_we never asserted.
REQ-037 SHALL cover: instr 0x00000033 -> DECODE->TRAP, illegal=1, byte_ready=0 for 20 cycles; rst -> state=0, pc=RESET_PC, illegal=0.
REQ-038 SHALL cover: rst after 2 accepted bytes -> cnt=0, instr=0; the next 4 bytes assemble a fresh instruction.
REQ-039 SHALL cover: pc=0xFFFFFFFC with ADDI -> pc wraps to 0x00000000; ADDI with rd=0 (0x00500013) -> rf_we stays 0.

Source files
------------

// File: rtl/riscv_seq_ctrl.sv
// riscv_seq_ctrl
//   Sequencing controller for a tiny RV32 subset (ADDI, LUI, BEQ). It gathers
//   an instruction one byte at a time from a byte bus, little-endian. It then
//   decodes the opcode, steers the datapath compare and write-back, and
//   advances the program counter. Any unsupported opcode parks the block in
//   TRAP until reset.
//
// Ports
//   clk         in   1   single clock, rising edge
//   rst         in   1   synchronous active-high reset
//   byte_in     in   8   instruction byte from the byte bus
//   byte_valid  in   1   byte_in is valid
//   byte_ready  out  1   block accepts a byte this cycle (FETCH only)
//   instr       out  32  assembled instruction register
//   imm         in   32  sign-extended immediate decoded from instr
//   alu_zero    in   1   datapath rs1 - rs2 == 0
//   pc          out  32  program counter
//   alu_sub     out  1   datapath compare uses subtract (BEQ in EXEC)
//   wb_sel      out  1   write-back source: 0 = ALU (ADDI), 1 = imm (LUI)
//   rf_we       out  1   register-file write strobe (WB only, rd != 0)
//   state       out  3   current FSM state, debug
//   illegal     out  1   sticky unsupported-opcode flag
//
// State table
//   state  | meaning
//   FETCH  | accept bytes until four have been assembled into instr
//   DECODE | classify opcode: legal -> EXEC, otherwise -> TRAP
//   EXEC   | BEQ resolves the branch and returns to FETCH; ADDI/LUI go on to WB
//   WB     | register write strobe, pc + 4
//   TRAP   | frozen until reset, illegal held high

module riscv_seq_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic [31:0] instr,
    input  logic [31:0] imm,
    input  logic        alu_zero,
    output logic [31:0] pc,
    output logic        alu_sub,
    output logic        wb_sel,
    output logic        rf_we,
    output logic [2:0]  state,
    output logic        illegal
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        WB     = 3'd3,
        TRAP   = 3'd4
    } state_e;

    localparam logic [6:0] OP_ADDI = 7'b0010011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;

    state_e      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q, pc_d;
    logic        illegal_q, illegal_d;

    logic [6:0]  opcode;
    logic        rd_zero;

    assign opcode  = instr_q[6:0];
    assign rd_zero = (instr_q[11:7] == 5'd0);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        instr_d   = instr_q;
        pc_d      = pc_q;
        illegal_d = illegal_q;
        unique case (state_q)
            FETCH: begin
                if (byte_valid) begin
                    instr_d[{cnt_q, 3'b000} +: 8] = byte_in;
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = DECODE;
                    end
                end
            end
            DECODE: begin
                if (opcode == OP_ADDI || opcode == OP_LUI || opcode == OP_BEQ) begin
                    state_d = EXEC;
                end else begin
                    state_d   = TRAP;
                    illegal_d = 1'b1;
                end
            end
            EXEC: begin
                if (opcode == OP_BEQ) begin
                    // Branch target is relative to the BEQ's own address.
                    pc_d    = alu_zero ? (pc_q + imm) : (pc_q + 32'd4);
                    state_d = FETCH;
                end else begin
                    state_d = WB;
                end
            end
            WB: begin
                pc_d    = pc_q + 32'd4;
                state_d = FETCH;
            end
            TRAP: begin
                state_d = TRAP;
            end
            default: begin
                state_d = TRAP;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FETCH;
            cnt_q     <= 2'd0;
            instr_q   <= 32'd0;
            pc_q      <= RESET_PC;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            instr_q   <= instr_d;
            pc_q      <= pc_d;
            illegal_q <= illegal_d;
        end
    end

    // Moore outputs: functions of the registered state and instruction only.
    assign byte_ready = (state_q == FETCH);
    assign alu_sub    = (state_q == EXEC) && (opcode == OP_BEQ);
    assign wb_sel     = (state_q == WB) && (opcode == OP_LUI);
    assign rf_we      = (state_q == WB) && !rd_zero;
    assign instr      = instr_q;
    assign pc         = pc_q;
    assign state      = state_q;
    assign illegal    = illegal_q;

endmodule

// File: tb/tb_riscv_seq_ctrl.sv
module tb_riscv_seq_ctrl;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic [31:0] instr;
    logic [31:0] imm;
    logic        alu_zero;
    logic [31:0] pc;
    logic        alu_sub;
    logic        wb_sel;
    logic        rf_we;
    logic [2:0]  state;
    logic        illegal;

    always #5 clk = ~clk;

    riscv_seq_ctrl #(.RESET_PC(RESET_PC)) dut (
        .clk        (clk),
        .rst        (rst),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .instr      (instr),
        .imm        (imm),
        .alu_zero   (alu_zero),
        .pc         (pc),
        .alu_sub    (alu_sub),
        .wb_sel     (wb_sel),
        .rf_we      (rf_we),
        .state      (state),
        .illegal    (illegal)
    );

    // Model: after a full instruction is assembled, the bench lays out a plan
    // of the cycles that must follow (what each one shows and does to pc).
    typedef struct packed {
        logic [2:0] st;
        logic       sub;
        logic       wsel;
        logic       we;
        logic       pc4;
        logic       branch;
        logic       to_trap;
    } plan_t;

    plan_t       plan[$];
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    int          m_n;
    bit          m_trap;
    bit          m_ill;

    int vectors     = 0;
    int miscompares = 0;

    function automatic plan_t mk(logic [2:0] st, logic sub, logic wsel, logic we,
                                 logic pc4, logic branch, logic to_trap);
        plan_t p;
        p.st = st; p.sub = sub; p.wsel = wsel; p.we = we;
        p.pc4 = pc4; p.branch = branch; p.to_trap = to_trap;
        return p;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_fetch();
        return (plan.size() == 0) && !m_trap;
    endfunction

    task automatic build_plan();
        logic [6:0] op;
        logic       rd_nz;
        op    = m_instr[6:0];
        rd_nz = (m_instr[11:7] != 5'd0);
        if (op == 7'h13 || op == 7'h37) begin
            plan.push_back(mk(3'd1, 0, 0, 0, 0, 0, 0));
            plan.push_back(mk(3'd2, 0, 0, 0, 0, 0, 0));
            plan.push_back(mk(3'd3, 0, (op == 7'h37), rd_nz, 1, 0, 0));
        end else if (op == 7'h63) begin
            plan.push_back(mk(3'd1, 0, 0, 0, 0, 0, 0));
            plan.push_back(mk(3'd2, 1, 0, 0, 0, 1, 0));
        end else begin
            plan.push_back(mk(3'd1, 0, 0, 0, 0, 0, 1));
        end
    endtask

    task automatic compare_all();
        logic [2:0] e_st;
        logic       e_sub, e_wsel, e_we;
        e_st = 3'd0; e_sub = 0; e_wsel = 0; e_we = 0;
        if (m_trap) begin
            e_st = 3'd4;
        end else if (plan.size() != 0) begin
            e_st   = plan[0].st;
            e_sub  = plan[0].sub;
            e_wsel = plan[0].wsel;
            e_we   = plan[0].we;
        end
        chk("state",      32'(state),      32'(e_st));
        chk("byte_ready", 32'(byte_ready), 32'(model_fetch()));
        chk("alu_sub",    32'(alu_sub),    32'(e_sub));
        chk("wb_sel",     32'(wb_sel),     32'(e_wsel));
        chk("rf_we",      32'(rf_we),      32'(e_we));
        chk("illegal",    32'(illegal),    32'(m_ill));
        chk("pc",         pc,              m_pc);
        chk("instr",      instr,           m_instr);
    endtask

    task automatic advance();
        plan_t e;
        if (rst) begin
            plan.delete();
            m_trap = 0; m_ill = 0; m_pc = RESET_PC; m_instr = 32'd0; m_n = 0;
        end else if (m_trap) begin
            // frozen
        end else if (plan.size() != 0) begin
            e = plan.pop_front();
            if (e.branch) m_pc = m_pc + (alu_zero ? imm : 32'd4);
            if (e.pc4) m_pc = m_pc + 32'd4;
            if (e.to_trap) begin m_trap = 1; m_ill = 1; end
        end else if (byte_valid) begin
            m_instr[8*m_n +: 8] = byte_in;
            m_n++;
            if (m_n == 4) begin
                m_n = 0;
                build_plan();
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        compare_all();
        advance();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(logic [7:0] b);
        int guard;
        guard = 0;
        byte_valid = 1'b1;
        byte_in    = b;
        while (!model_fetch() && guard < 50) begin
            step();
            guard++;
        end
        if (guard >= 50) begin
            vectors++;
            miscompares++;
            $display("FAIL feed_timeout: got no byte_ready expected byte_ready within 50 cycles");
        end
        step();
        byte_valid = 1'b0;
    endtask

    task automatic feed_word(logic [31:0] w);
        for (int k = 0; k < 4; k++) feed(w[8*k +: 8]);
    endtask

    task automatic idle(int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        rst = 1'b1; byte_valid = 1'b0; byte_in = 8'h00; imm = 32'd0; alu_zero = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        advance();
        step();
        rst = 1'b0;
        chk("lit_reset_pc", pc, 32'h0);
        chk("lit_reset_state", 32'(state), 32'd0);
        chk("lit_reset_ready", 32'(byte_ready), 32'd1);
        chk("lit_reset_instr", instr, 32'h0);

        // ADDI x1, x0, 5 back-to-back
        feed_word(32'h0050_0093);
        idle(2);
        chk("lit_addi_state_wb", 32'(state), 32'd3);
        chk("lit_addi_rf_we", 32'(rf_we), 32'd1);
        chk("lit_addi_wb_sel", 32'(wb_sel), 32'd0);
        chk("lit_addi_instr", instr, 32'h0050_0093);
        idle(1);
        chk("lit_addi_pc", pc, 32'h4);

        // LUI x2, 0x12345 with a 5-cycle gap after byte 2
        feed(8'h37); feed(8'h51);
        idle(5);
        feed(8'h34); feed(8'h12);
        idle(2);
        chk("lit_lui_wb_sel", 32'(wb_sel), 32'd1);
        chk("lit_lui_rf_we", 32'(rf_we), 32'd1);
        chk("lit_lui_instr", instr, 32'h1234_5137);
        idle(1);
        chk("lit_lui_pc", pc, 32'h8);

        feed_word(32'h0050_0093); idle(3);
        feed_word(32'h0050_0093); idle(3);
        chk("lit_pc_10", pc, 32'h10);

        // BEQ +8 taken, then not taken
        imm = 32'd8; alu_zero = 1'b1;
        feed_word(32'h0000_0463); idle(2);
        chk("lit_beq_taken", pc, 32'h18);
        alu_zero = 1'b0;
        feed_word(32'h0000_0463); idle(2);
        chk("lit_beq_not_taken", pc, 32'h1C);

        // Jump to 0xFFFFFFFC, then ADDI x0 wraps pc and does not write
        imm = 32'hFFFF_FFE0; alu_zero = 1'b1;
        feed_word(32'h0000_0463); idle(2);
        chk("lit_pc_top", pc, 32'hFFFF_FFFC);
        feed_word(32'h0050_0013); idle(2);
        chk("lit_rd0_state", 32'(state), 32'd3);
        chk("lit_rd0_rf_we", 32'(rf_we), 32'd0);
        idle(1);
        chk("lit_pc_wrap", pc, 32'h0);

        // Reset during a partial instruction
        feed(8'hAA); feed(8'hBB);
        rst = 1'b1; step(); rst = 1'b0;
        chk("lit_rst_instr", instr, 32'h0);
        feed_word(32'h0050_0093);
        chk("lit_fresh_instr", instr, 32'h0050_0093);
        idle(3);

        // Illegal opcode
        feed_word(32'h0000_0033);
        step();
        for (int k = 0; k < 20; k++) begin
            byte_valid = 1'b1;
            byte_in    = 8'($urandom);
            step();
        end
        byte_valid = 1'b0;
        chk("lit_trap_state", 32'(state), 32'd4);
        chk("lit_trap_illegal", 32'(illegal), 32'd1);
        chk("lit_trap_pc", pc, 32'h4);
        rst = 1'b1; step(); rst = 1'b0;
        chk("lit_trap_rst_state", 32'(state), 32'd0);
        chk("lit_trap_rst_illegal", 32'(illegal), 32'd0);
        chk("lit_trap_rst_pc", pc, RESET_PC);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int r;
            rst        = m_trap ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 299) == 0);
            byte_valid = ($urandom_range(0, 9) < 7);
            if (m_n == 0) begin
                r = $urandom_range(0, 9);
                if (r < 3)      byte_in = {1'($urandom), 7'h13};
                else if (r < 5) byte_in = {1'($urandom), 7'h37};
                else if (r < 7) byte_in = {1'($urandom), 7'h63};
                else            byte_in = 8'($urandom);
            end else begin
                byte_in = 8'($urandom);
            end
            imm      = $urandom;
            alu_zero = 1'($urandom);
            step();
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
